uart_rx_param: RTL and testbench

- Parametrised UART receiver; the next generation of the fixed 8-bit receive path in the UART verification environment.
- Adds the following, with a ready/ack handshake toward the consumer:
  - configurable data width, parity mode and stop-bit count;
  - a clocks-per-bit divisor;
  - 3-sample majority voting;
  - false-start rejection, overrun and break detection.
- Sits between the rx pin and the host-side receive register.

---
 rtl/uart_rx_param.sv | 213 +++++++++++++++++++++
 tb/tb_uart_rx_param.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver with majority-vote sampling.
//
// The receiver synchronises the rx line with two flops. It detects a start edge
// and then rejects false starts. Data bits arrive LSB first, followed by an
// optional parity bit and 1 or 2 stop bits. Each completed frame is passed to
// the consumer through a data_ready / data_ack handshake.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   rx_en        receiver enable (level); low forces the FSM back to IDLE
//   rx           serial line, idle high, asynchronous to clk
//   data_ack     one-cycle pulse, consumer has taken data_out
//   data_out     payload of the last accepted frame
//   data_ready   level, held until data_ack
//   parity_error parity mismatch on the last accepted frame
//   stop_error   a stop bit was sampled 0 on the last accepted frame
//   overrun      sticky, a frame completed while data_ready was still set
//   break_det    one-cycle pulse on an all-zero frame (reported even if discarded)
module uart_rx_param #(
  parameter int DATA_WIDTH   = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx_en,
  input  logic                  rx,
  input  logic                  data_ack,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_ready,
  output logic                  parity_error,
  output logic                  stop_error,
  output logic                  overrun,
  output logic                  break_det
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_WIDTH) + 1;
  localparam int M  = CLKS_PER_BIT / 2;
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] SAMP_A    = CW'(M - 1);
  localparam logic [CW-1:0] SAMP_B    = CW'(M);
  localparam logic [CW-1:0] SAMP_C    = CW'(M + 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic          HAS_PAR   = (PARITY == 32'sd1) || (PARITY == 32'sd2);
  localparam logic          ODD_PAR   = (PARITY == 32'sd2);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_PAR   = 3'd3,
    S_STOP  = 3'd4
  } state_t;

  // Expected parity bit for a payload: even parity is the XOR, odd its inverse.
  function automatic logic expected_parity(input logic [DATA_WIDTH-1:0] d,
                                           input logic odd);
    expected_parity = (^d) ^ odd;
  endfunction

  state_t                  state_r, state_nxt_s;
  logic                    sync1_r, sync2_r, prev_r;
  logic [CW-1:0]           cnt_r;
  logic                    samp_a_r, samp_b_r;
  logic [BW-1:0]           bit_idx_r;
  logic                    stop_idx_r;
  logic                    stop_flag_r;
  logic                    par_bit_r;
  logic [DATA_WIDTH-1:0]   shift_r;

  logic rxs_s, fall_s, mid_s, maj_s, done_s;
  logic frame_stop_err_s, frame_par_err_s, frame_break_s;

  assign rxs_s  = sync2_r;
  assign fall_s = prev_r & ~rxs_s;
  assign mid_s  = (state_r != S_IDLE) && (cnt_r == SAMP_C);
  // Third sample is the live value; the first two were captured on the previous cycles.
  assign maj_s  = (samp_a_r & samp_b_r) | (samp_a_r & rxs_s) | (samp_b_r & rxs_s);
  assign done_s = rx_en && (state_r == S_STOP) && mid_s && (stop_idx_r == STOP_LAST);

  // The final stop bit is still only in maj_s when the frame completes.
  assign frame_stop_err_s = stop_flag_r | ~maj_s;
  assign frame_par_err_s  = HAS_PAR && (par_bit_r != expected_parity(shift_r, ODD_PAR));
  assign frame_break_s    = (shift_r == '0) && !par_bit_r && frame_stop_err_s;

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    if (!rx_en) begin
      state_nxt_s = S_IDLE;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (fall_s) state_nxt_s = S_START;
          else        state_nxt_s = S_IDLE;
        end
        S_START: begin
          if (mid_s) state_nxt_s = maj_s ? S_IDLE : S_DATA;
          else       state_nxt_s = S_START;
        end
        S_DATA: begin
          if (mid_s && (bit_idx_r == BIT_LAST)) state_nxt_s = HAS_PAR ? S_PAR : S_STOP;
          else                                  state_nxt_s = S_DATA;
        end
        S_PAR: begin
          if (mid_s) state_nxt_s = S_STOP;
          else       state_nxt_s = S_PAR;
        end
        S_STOP: begin
          if (mid_s && (stop_idx_r == STOP_LAST)) state_nxt_s = S_IDLE;
          else                                    state_nxt_s = S_STOP;
        end
        default: state_nxt_s = S_IDLE;
      endcase
    end
  end

  // Synchroniser, bit timing, sampling and frame shift register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_r     <= 1'b1;
      sync2_r     <= 1'b1;
      prev_r      <= 1'b1;
      cnt_r       <= '0;
      samp_a_r    <= 1'b1;
      samp_b_r    <= 1'b1;
      bit_idx_r   <= '0;
      stop_idx_r  <= 1'b0;
      stop_flag_r <= 1'b0;
      par_bit_r   <= 1'b0;
      shift_r     <= '0;
    end else begin
      sync1_r <= rx;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;

      // The counter runs freely through the whole frame so the bit period never drifts.
      if ((state_r == S_IDLE) || (state_nxt_s == S_IDLE)) begin
        cnt_r <= '0;
      end else if (cnt_r == CNT_LAST) begin
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
      end

      if (cnt_r == SAMP_A) samp_a_r <= rxs_s;
      if (cnt_r == SAMP_B) samp_b_r <= rxs_s;

      if (state_r != S_DATA) begin
        bit_idx_r <= '0;
      end else if (mid_s) begin
        bit_idx_r <= bit_idx_r + {{(BW-1){1'b0}}, 1'b1};
      end

      if (state_r != S_STOP) begin
        stop_idx_r <= 1'b0;
      end else if (mid_s) begin
        stop_idx_r <= ~stop_idx_r;
      end

      if (state_r == S_START) begin
        stop_flag_r <= 1'b0;
        par_bit_r   <= 1'b0;
      end else begin
        if ((state_r == S_STOP) && mid_s && !maj_s) stop_flag_r <= 1'b1;
        if ((state_r == S_PAR) && mid_s)            par_bit_r   <= maj_s;
      end

      if ((state_r == S_DATA) && mid_s) shift_r <= {maj_s, shift_r[DATA_WIDTH-1:1]};
    end
  end

  // Host-side handshake: accept or discard completed frames, ack clears.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_out     <= '0;
      data_ready   <= 1'b0;
      parity_error <= 1'b0;
      stop_error   <= 1'b0;
      overrun      <= 1'b0;
      break_det    <= 1'b0;
    end else begin
      break_det <= done_s && frame_break_s;
      if (done_s) begin
        if (!data_ready || data_ack) begin
          data_out     <= shift_r;
          parity_error <= frame_par_err_s;
          stop_error   <= frame_stop_err_s;
          data_ready   <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (data_ack && data_ready) begin
        data_ready <= 1'b0;
        overrun    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed testbench for uart_rx_param (8 data bits, even parity, 1 stop, 16 clk/bit).
module tb_uart_rx_param;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_en;
  logic       rx;
  logic       data_ack;
  logic [7:0] data_out;
  logic       data_ready, parity_error, stop_error, overrun, break_det;

  int checks = 0;
  int errors = 0;
  int brk_cnt = 0;

  uart_rx_param #(
    .DATA_WIDTH(8), .PARITY(1), .STOP_BITS(1), .CLKS_PER_BIT(16)
  ) dut (
    .clk(clk), .reset(reset), .rx_en(rx_en), .rx(rx), .data_ack(data_ack),
    .data_out(data_out), .data_ready(data_ready), .parity_error(parity_error),
    .stop_error(stop_error), .overrun(overrun), .break_det(break_det)
  );

  always #5 clk = ~clk;

  // Counts every cycle break_det is observed high.
  always @(negedge clk) begin
    if (break_det === 1'b1) brk_cnt = brk_cnt + 1;
  end

  // One bit period; spike_at >= 0 inverts the line for that single clk.
  task automatic send_bit(input logic b, input int spike_at);
    for (int i = 0; i < 16; i++) begin
      rx = (i == spike_at) ? ~b : b;
      @(negedge clk);
    end
  endtask

  // Full frame: start, 8 data LSB first, parity, stop, then idle.
  // drop_bit >= 0 drops rx_en at the start of that data bit.
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp,
                            input int spike_bit, input int spike_at, input int drop_bit,
                            input int idle);
    send_bit(1'b0, -1);
    for (int i = 0; i < 8; i++) begin
      if (i == drop_bit) rx_en = 1'b0;
      send_bit(d[i], (i == spike_bit) ? spike_at : -1);
    end
    send_bit(par, -1);
    send_bit(stp, -1);
    rx = 1'b1;
    repeat (idle) @(negedge clk);
  endtask

  task automatic pulse_ack();
    data_ack = 1'b1;
    @(negedge clk);
    data_ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (data_ready !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (data_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s timeout: data_ready=%b required 1", name, data_ready);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; rx_en = 1'b1; rx = 1'b1; data_ack = 1'b0;
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({data_out, data_ready, parity_error, stop_error, overrun, break_det} !== 13'd0) begin
      errors++;
      $display("FAIL reset_outputs: got out=%h rdy=%b pe=%b se=%b ov=%b brk=%b required all 0",
               data_out, data_ready, parity_error, stop_error, overrun, break_det);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_good_frame();
    int b0;
    b0 = brk_cnt;
    send_frame(8'hA5, 1'b0, 1'b1, -1, -1, -1, 4);
    wait_ready("t1_ready");
    checks++;
    if (data_out !== 8'hA5) begin errors++; $display("FAIL t1_data: got %h required a5", data_out); end
    checks++;
    if (parity_error !== 1'b0 || stop_error !== 1'b0) begin
      errors++; $display("FAIL t1_errs: got pe=%b se=%b required 0 0", parity_error, stop_error);
    end
    checks++;
    if (brk_cnt - b0 !== 0) begin errors++; $display("FAIL t1_break: got %0d required 0", brk_cnt - b0); end
    repeat (20) @(negedge clk);
    checks++;
    if (data_ready !== 1'b1) begin errors++; $display("FAIL t1_hold: got %b required 1", data_ready); end
    pulse_ack();
    checks++;
    if (data_ready !== 1'b0 || data_out !== 8'hA5) begin
      errors++; $display("FAIL t1_ack: got rdy=%b out=%h required 0 a5", data_ready, data_out);
    end
  endtask

  task automatic test_parity_error();
    send_frame(8'h3C, 1'b1, 1'b1, -1, -1, -1, 4);
    wait_ready("t2_ready");
    checks++;
    if (data_out !== 8'h3C || parity_error !== 1'b1 || stop_error !== 1'b0) begin
      errors++;
      $display("FAIL t2_parity: got out=%h pe=%b se=%b required 3c 1 0", data_out, parity_error, stop_error);
    end
    pulse_ack();
  endtask

  task automatic test_break();
    int b0;
    b0 = brk_cnt;
    send_frame(8'h00, 1'b0, 1'b0, -1, -1, -1, 4);
    wait_ready("t3_ready");
    checks++;
    if (data_out !== 8'h00 || stop_error !== 1'b1 || parity_error !== 1'b0) begin
      errors++;
      $display("FAIL t3_stop: got out=%h se=%b pe=%b required 00 1 0", data_out, stop_error, parity_error);
    end
    checks++;
    if (brk_cnt - b0 !== 1) begin
      errors++; $display("FAIL t3_break_width: got %0d cycles required 1", brk_cnt - b0);
    end
    pulse_ack();
  endtask

  task automatic test_false_start_and_spike();
    rx = 1'b0;
    repeat (5) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    checks++;
    if (data_ready !== 1'b0) begin errors++; $display("FAIL t4_false_start: got rdy=%b required 0", data_ready); end
    // Spike at the middle sample of data bit 0 (a 0 bit).
    send_frame(8'h5A, 1'b0, 1'b1, 0, 9, -1, 4);
    wait_ready("t4_ready");
    checks++;
    if (data_out !== 8'h5A || parity_error !== 1'b0 || stop_error !== 1'b0) begin
      errors++;
      $display("FAIL t4_spike: got out=%h pe=%b se=%b required 5a 0 0", data_out, parity_error, stop_error);
    end
    pulse_ack();
  endtask

  task automatic test_back_to_back();
    send_frame(8'h11, 1'b0, 1'b1, -1, -1, -1, 0);
    send_frame(8'h22, 1'b0, 1'b1, -1, -1, -1, 4);
    checks++;
    if (data_ready !== 1'b1 || data_out !== 8'h11 || overrun !== 1'b1) begin
      errors++;
      $display("FAIL t5_overrun: got rdy=%b out=%h ov=%b required 1 11 1", data_ready, data_out, overrun);
    end
    pulse_ack();
    checks++;
    if (data_ready !== 1'b0 || overrun !== 1'b0) begin
      errors++; $display("FAIL t5_ack: got rdy=%b ov=%b required 0 0", data_ready, overrun);
    end
  endtask

  task automatic test_enable_and_reset();
    send_frame(8'h77, 1'b0, 1'b1, -1, -1, 3, 20);
    checks++;
    if (data_ready !== 1'b0) begin errors++; $display("FAIL t6_drop: got rdy=%b required 0", data_ready); end
    rx_en = 1'b1;
    repeat (4) @(negedge clk);
    send_frame(8'h42, 1'b0, 1'b1, -1, -1, -1, 4);
    wait_ready("t6_ready");
    checks++;
    if (data_out !== 8'h42 || overrun !== 1'b0) begin
      errors++; $display("FAIL t6_data: got out=%h ov=%b required 42 0", data_out, overrun);
    end
    // Leave 0x42 pending, start another frame and reset it mid-way.
    send_bit(1'b0, -1);
    send_bit(1'b1, -1);
    send_bit(1'b0, 5);
    reset = 1'b0;
    #1;
    checks++;
    if ({data_out, data_ready, parity_error, stop_error, overrun, break_det} !== 13'd0) begin
      errors++;
      $display("FAIL t6_reset_midframe: got out=%h rdy=%b pe=%b se=%b ov=%b brk=%b required all 0",
               data_out, data_ready, parity_error, stop_error, overrun, break_det);
    end
    rx = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    repeat (200) @(negedge clk);
    checks++;
    if (data_ready !== 1'b0) begin errors++; $display("FAIL t6_no_partial: got rdy=%b required 0", data_ready); end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_parity_error();
    test_break();
    test_false_start_and_spike();
    test_back_to_back();
    test_enable_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
